lstm_cell_seq: RTL

Time-multiplexed, parametrised LSTM cell with Q(WIDTH-FRAC).FRAC fixed-point datapath and configurable input/hidden lengths.
- Consumes the concatenated vector [x(t); h(t-1)] one element per beat over a valid/ready stream, with four gate weights per beat.
- Accumulates the four gate pre-activations serially, then applies the gate nonlinearities and performs the cell/hidden update in a fixed pipeline.
- Presents h(t) and c(t) through a second valid/ready handshake.
- Keeps c(t-1) internally across timesteps; it is the sequenced building block for the LSTM layer controller.

---
 rtl/lstm_pkg.sv | 51 +++++
 rtl/lstm_cell_seq_act.sv | 36 +++
 rtl/lstm_cell_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared fixed-point helpers and FSM encoding for the LSTM cell
package lstm_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 24;

    // Wide enough for every intermediate in the cell (accumulators, products, sums).
    localparam int SAT_W = 128;

    typedef logic signed [SAT_W-1:0] wide_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_ACT  = 3'd2,
        S_CELL = 3'd3,
        S_HOUT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // 1.0 in a format with frac fractional bits.
    function automatic wide_t fx_one(input int frac);
        return wide_t'(1) <<< frac;
    endfunction

    // 0.5 in a format with frac fractional bits.
    function automatic wide_t fx_half(input int frac);
        return fx_one(frac) >>> 1;
    endfunction

    // Largest value representable in a w-bit signed word.
    function automatic wide_t fx_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    // Smallest value representable in a w-bit signed word.
    function automatic wide_t fx_min(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    // Clamp v into the w-bit signed range; caller narrows with a size cast.
    function automatic wide_t sat(input wide_t v, input int w);
        if (v > fx_max(w)) begin
            return fx_max(w);
        end else if (v < fx_min(w)) begin
            return fx_min(w);
        end
        return v;
    endfunction

endpackage

// File: rtl/lstm_cell_seq_act.sv
// rtl/lstm_cell_seq_act.sv - combinational hard_tanh / hard_sigmoid activation
module lstm_act_pwl
    import lstm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                    i_sig,
    input  logic signed [WIDTH-1:0] i_x,
    output logic signed [WIDTH-1:0] o_y
);

    localparam wide_t L_ONE  = fx_one(FRAC);
    localparam wide_t L_HALF = fx_half(FRAC);

    wide_t w_t;
    wide_t w_lo;

    // Sigmoid mode maps x to x/4 + 0.5 clamped to [0,1]; tanh mode clamps x to [-1,1].
    always_comb begin
        w_t  = wide_t'(i_x);
        w_lo = -L_ONE;
        if (i_sig) begin
            w_t  = (wide_t'(i_x) >>> 2) + L_HALF;
            w_lo = '0;
        end
        if (w_t > L_ONE) begin
            o_y = WIDTH'(L_ONE);
        end else if (w_t < w_lo) begin
            o_y = WIDTH'(w_lo);
        end else begin
            o_y = WIDTH'(w_t);
        end
    end

endmodule

// File: rtl/lstm_cell_seq.sv
// rtl/lstm_cell_seq.sv - time-multiplexed LSTM cell with serial MAC and fixed activation pipeline
module lstm_cell_seq
    import lstm_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int NUM      = 68,
    parameter int NUM_LSTM = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_first,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_w_a,
    input  logic signed [WIDTH-1:0] i_w_i,
    input  logic signed [WIDTH-1:0] i_w_f,
    input  logic signed [WIDTH-1:0] i_w_o,
    input  logic signed [WIDTH-1:0] i_b_a,
    input  logic signed [WIDTH-1:0] i_b_i,
    input  logic signed [WIDTH-1:0] i_b_f,
    input  logic signed [WIDTH-1:0] i_b_o,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [WIDTH-1:0] o_a,
    output logic signed [WIDTH-1:0] o_i,
    output logic signed [WIDTH-1:0] o_f,
    output logic signed [WIDTH-1:0] o_o,
    output logic signed [WIDTH-1:0] o_c,
    output logic signed [WIDTH-1:0] o_h,
    output logic                    o_busy
);

    localparam int LEN = NUM + NUM_LSTM;
    localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int PW  = 2 * WIDTH;
    localparam int AW  = PW + $clog2(LEN);

    // Gate lane order: 0 = a (candidate), 1 = i, 2 = f, 3 = o.
    state_t                  r_state;
    state_t                  w_next;
    logic        [CW-1:0]    r_cnt;
    logic                    r_first;
    logic signed [AW-1:0]    r_acc  [4];
    logic signed [WIDTH-1:0] r_b    [4];
    logic signed [WIDTH-1:0] r_gate [4];
    logic signed [WIDTH-1:0] r_c;
    logic signed [WIDTH-1:0] r_h;
    logic signed [WIDTH-1:0] r_c_reg;

    logic signed [WIDTH-1:0] w_ma   [4];
    logic signed [WIDTH-1:0] w_mb   [4];
    logic signed [PW-1:0]    w_p    [4];
    logic signed [WIDTH-1:0] w_pre  [4];
    logic signed [WIDTH-1:0] w_act  [4];
    logic signed [WIDTH-1:0] w_c_prev;
    logic signed [WIDTH-1:0] w_tanh_c;
    logic signed [WIDTH-1:0] w_c_new;
    logic signed [WIDTH-1:0] w_h_new;
    logic                    w_last;

    assign w_last   = (r_cnt == CW'(LEN - 1));
    assign w_c_prev = r_first ? '0 : r_c_reg;

    assign o_a = r_gate[0];
    assign o_i = r_gate[1];
    assign o_f = r_gate[2];
    assign o_o = r_gate[3];
    assign o_c = r_c;
    assign o_h = r_h;

    // State register; reset aborts any timestep in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_ACC;
                end
            end
            S_ACC: begin
                o_ready = 1'b1;
                if (i_valid && w_last) begin
                    w_next = S_ACT;
                end
            end
            S_ACT:  w_next = S_CELL;
            S_CELL: w_next = S_HOUT;
            S_HOUT: w_next = S_DONE;
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The four MAC multipliers are borrowed for the cell and hidden updates once accumulation ends.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            w_ma[g] = i_x;
        end
        w_mb[0] = i_w_a;
        w_mb[1] = i_w_i;
        w_mb[2] = i_w_f;
        w_mb[3] = i_w_o;
        if (r_state == S_CELL) begin
            w_ma[0] = r_gate[0];
            w_mb[0] = r_gate[1];
            w_ma[1] = r_gate[2];
            w_mb[1] = w_c_prev;
        end else if (r_state == S_HOUT) begin
            w_ma[0] = r_gate[3];
            w_mb[0] = w_tanh_c;
        end
    end

    // Full-precision signed products for each lane.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            w_p[g] = PW'(w_ma[g]) * PW'(w_mb[g]);
        end
    end

    // Gate pre-activations: rescale the accumulator, saturate, then add the bias with saturation.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            w_pre[g] = WIDTH'(sat(sat(wide_t'(r_acc[g] >>> FRAC), WIDTH) + wide_t'(r_b[g]), WIDTH));
        end
    end

    // Cell state c = a*i + f*c_prev and hidden h = o*tanh(c), each term saturated.
    always_comb begin
        w_c_new = WIDTH'(sat(sat(wide_t'(w_p[0] >>> FRAC), WIDTH)
                           + sat(wide_t'(w_p[1] >>> FRAC), WIDTH), WIDTH));
        w_h_new = WIDTH'(sat(wide_t'(w_p[0] >>> FRAC), WIDTH));
    end

    for (genvar g = 0; g < 4; g++) begin : g_act
        lstm_act_pwl #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_act (
            .i_sig (g != 0),
            .i_x   (w_pre[g]),
            .o_y   (w_act[g])
        );
    end

    lstm_act_pwl #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_act_c (
        .i_sig (1'b0),
        .i_x   (r_c),
        .o_y   (w_tanh_c)
    );

    // Datapath registers: bias/flag capture, accumulation, and the ACT/CELL/HOUT result stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_c     <= '0;
            r_h     <= '0;
            r_c_reg <= '0;
            for (int g = 0; g < 4; g++) begin
                r_acc[g]  <= '0;
                r_b[g]    <= '0;
                r_gate[g] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_first <= i_first;
                        r_cnt   <= '0;
                        r_b[0]  <= i_b_a;
                        r_b[1]  <= i_b_i;
                        r_b[2]  <= i_b_f;
                        r_b[3]  <= i_b_o;
                        for (int g = 0; g < 4; g++) begin
                            r_acc[g] <= '0;
                        end
                    end
                end
                S_ACC: begin
                    if (i_valid) begin
                        r_cnt <= r_cnt + CW'(1);
                        for (int g = 0; g < 4; g++) begin
                            r_acc[g] <= r_acc[g] + AW'(w_p[g]);
                        end
                    end
                end
                S_ACT: begin
                    for (int g = 0; g < 4; g++) begin
                        r_gate[g] <= w_act[g];
                    end
                end
                S_CELL: r_c <= w_c_new;
                S_HOUT: r_h <= w_h_new;
                S_DONE: begin
                    if (i_ready) begin
                        r_c_reg <= r_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
